// File: rtl/skew_mon_pkg.sv
// skew_mon_pkg: state encoding and default widths for the skew window monitor
package skew_mon_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] A_WAIT = 2'd1;
  localparam logic [1:0] B_WAIT = 2'd2;
  localparam int CNT_W_DEF = 8;
  localparam int VCNT_W_DEF = 16;
endpackage

// File: rtl/skew_window_monitor_rise_detect.sv
// rise_detect: one-cycle history register and rising-edge AND
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk)
    if (!rst_n) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
endmodule

// File: rtl/skew_window_monitor.sv
// skew_window_monitor: measures rising-edge separation of two strobes and flags out-of-window skew
import skew_mon_pkg::*;
module skew_window_monitor #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int VCNT_W = VCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sig_a,
  input  logic              sig_b,
  input  logic [CNT_W-1:0]  skew_limit,
  input  logic              clr,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  skew_val,
  output logic              a_lead,
  output logic              viol,
  output logic              viol_flag,
  output logic [VCNT_W-1:0] viol_cnt,
  output logic              busy
);
  logic ea, eb, ea_r, eb_r;
  logic [1:0] state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, lim, lim_d, skew_d;
  logic waiting, own, other, tmo, pair, timeout, lead_d, viol_d;
  rise_detect u_rise_a (.clk(clk), .rst_n(rst_n), .d(sig_a), .rise(ea));
  rise_detect u_rise_b (.clk(clk), .rst_n(rst_n), .d(sig_b), .rise(eb));
  always_ff @(posedge clk)
    if (!rst_n) {ea_r, eb_r} <= 2'b00;
    else {ea_r, eb_r} <= {ea, eb};
  assign waiting = state != IDLE;
  assign own = state == A_WAIT ? ea_r : eb_r;
  assign other = state == A_WAIT ? eb_r : ea_r;
  assign tmo = cnt >= lim;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      lim <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      lim <= lim_d;
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    lim_d = lim;
    if (!waiting) begin
      if (en & (ea_r ^ eb_r)) begin
        state_d = ea_r ? A_WAIT : B_WAIT;
        cnt_d = CNT_W'(1);
        lim_d = skew_limit;
      end
    end else if (!en || other || tmo) begin
      state_d = IDLE;
    end else if (own) begin
      cnt_d = CNT_W'(1);
      lim_d = skew_limit;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
  end
  always_comb begin
    pair = en & (waiting ? other : ea_r & eb_r);
    timeout = en & waiting & ~other & tmo;
    skew_d = !waiting ? '0 : pair ? cnt : (&lim ? lim : lim + CNT_W'(1));
    lead_d = state != B_WAIT;
    viol_d = timeout | (pair & waiting & (cnt > lim));
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      meas_valid <= 1'b0;
      viol <= 1'b0;
      skew_val <= '0;
      a_lead <= 1'b0;
      viol_flag <= 1'b0;
      viol_cnt <= '0;
    end else begin
      meas_valid <= pair;
      viol <= viol_d;
      if (pair | timeout) begin
        skew_val <= skew_d;
        a_lead <= lead_d;
      end
      if (viol_d) begin
        viol_flag <= 1'b1;
        viol_cnt <= clr ? VCNT_W'(1) : (&viol_cnt ? viol_cnt : viol_cnt + VCNT_W'(1));
      end else if (clr) begin
        viol_flag <= 1'b0;
        viol_cnt <= '0;
      end
    end
  assign busy = waiting;
endmodule
